// File: rtl/ch0re_ifetch.sv
// Instruction fetch front end: one outstanding memory request at a time,
// a two-entry {pc, instr, err} queue feeding the decoder, and a redirect
// path that flushes the queue and discards any response still in flight.
module ch0re_ifetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_err,
  input  logic        i_pl_stall,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [63:0] o_pc,
  output logic        o_fetch_err
);

  // FETCH: may issue; WAIT: response owed and wanted; DROP: response owed but stale
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] fetch_pc;
  logic [63:0] req_pc;
  logic [63:0] redirect_target;

  logic [63:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        fifo_err   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        req;
  logic        grant;
  logic        push;
  logic        pop;

  // Request/push/pop qualifiers; a redirect suppresses all three in its cycle.
  // Outstanding is zero whenever state is FETCH, so occupancy alone gates req.
  always_comb begin
    req             = 1'b0;
    grant           = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    redirect_target = i_redirect_pc & ~64'h3;
    if (!rst && (state == FETCH) && (count < 2'd2) && !i_redirect) begin
      req = 1'b1;
    end else begin
      req = 1'b0;
    end
    grant = req & i_imem_gnt;
    push  = (state == WAIT) & i_imem_rvalid & ~i_redirect;
    pop   = (count != 2'd0) & ~i_pl_stall & ~i_redirect;
  end

  // Next-state logic for the fetch FSM.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (grant) begin
          state_next = WAIT;
        end else begin
          state_next = FETCH;
        end
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          state_next = FETCH;
        end else if (i_redirect) begin
          state_next = DROP;
        end else begin
          state_next = WAIT;
        end
      end
      DROP: begin
        if (i_imem_rvalid) begin
          state_next = FETCH;
        end else begin
          state_next = DROP;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // FSM state, fetch address and the address of the request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state <= state_next;
      if (i_redirect) begin
        fetch_pc <= redirect_target;
      end else if (grant) begin
        fetch_pc <= fetch_pc + 64'd4;
        req_pc   <= fetch_pc;
      end
    end
  end

  // Instruction queue; a redirect empties it ahead of any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= 64'h0;
        fifo_instr[i] <= 32'h0;
        fifo_err[i]   <= 1'b0;
      end
    end else if (i_redirect) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= req_pc;
        fifo_instr[wr_ptr] <= i_imem_err ? 32'h0 : i_imem_rdata;
        fifo_err[wr_ptr]   <= i_imem_err;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign o_imem_req  = req;
  assign o_imem_addr = fetch_pc;
  assign o_valid     = (count != 2'd0);
  assign o_instr     = fifo_instr[rd_ptr];
  assign o_pc        = fifo_pc[rd_ptr];
  assign o_fetch_err = fifo_err[rd_ptr];

endmodule
